// File: rtl/sobel_pkg.sv
// Shared types and arithmetic helpers for the streaming 3x3 Sobel edge detector.
package sobel_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int GRAD_WIDTH = 11;
  localparam int MAG_WIDTH  = 11;

  // Clamp the gradient magnitude into an 8-bit pixel.
  function automatic logic [7:0] sat8(input logic [MAG_WIDTH-1:0] mag);
    return (mag > MAG_WIDTH'(255)) ? 8'hFF : mag[7:0];
  endfunction

endpackage

// File: rtl/gray_sobel_edge_if.sv
// Pixel stream in/out bundle for gray_sobel_edge: upstream gray pixels in, edge pixels out.
interface gray_sobel_edge_if #(
  parameter int DATA_COLOR_WIDTH = 8
);
  logic                        en;
  logic                        valid_in;
  logic [DATA_COLOR_WIDTH-1:0] data_in;
  logic [DATA_COLOR_WIDTH-1:0] data_out;
  logic                        valid_out;
  logic                        frame_done;
  logic                        busy;

  modport master (
    output en, valid_in, data_in,
    input  data_out, valid_out, frame_done, busy
  );

  modport slave (
    input  en, valid_in, data_in,
    output data_out, valid_out, frame_done, busy
  );
endinterface

// File: rtl/sobel_line_buffer.sv
// DEPTH-step delay line: dout is the value written DEPTH steps earlier.
module sobel_line_buffer #(
  parameter int DEPTH = 480,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             step,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] ptr_q, ptr_d;

  assign dout = mem[ptr_q];

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    ptr_d = ptr_q;
    if (step) ptr_d = (ptr_q == PTR_W'(DEPTH-1)) ? '0 : ptr_q + 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ptr_q <= '0;
    else          ptr_q <= ptr_d;
  end

  // NOTE: the storage array is deliberately not reset; stale contents only reach border outputs.
  always_ff @(posedge clk) begin
    if (step) mem[ptr_q] <= din;
  end

endmodule

// File: rtl/gray_sobel_edge.sv
// Streaming 3x3 Sobel edge magnitude over a raster gray stream, with end-of-frame flush.
module gray_sobel_edge
  import sobel_pkg::*;
#(
  parameter int IMAGE_HEIGHT     = 270,
  parameter int IMAGE_WIDTH      = 480,
  parameter int DATA_COLOR_WIDTH = 8,
  parameter int COL_WIDTH        = 9,
  parameter int ROW_WIDTH        = 9
) (
  input logic              clk,
  input logic              reset_n,
  gray_sobel_edge_if.slave io
);

  typedef logic [DATA_COLOR_WIDTH-1:0] pix_t;
  typedef logic [COL_WIDTH-1:0]        col_t;
  typedef logic [ROW_WIDTH-1:0]        row_t;
  typedef logic [COL_WIDTH:0]          cnt_t;

  localparam col_t COL_LAST   = col_t'(IMAGE_WIDTH - 1);
  localparam row_t ROW_LAST   = row_t'(IMAGE_HEIGHT - 1);
  localparam cnt_t FLUSH_LAST = cnt_t'(IMAGE_WIDTH);
  localparam cnt_t LEAD_FULL  = cnt_t'(IMAGE_WIDTH + 1);

  state_e state_q, state_d;
  col_t   in_col_q, in_col_d, out_col_q, out_col_d;
  row_t   in_row_q, in_row_d, out_row_q, out_row_d;
  cnt_t   flush_cnt_q, flush_cnt_d, lead_cnt_q, lead_cnt_d;
  pix_t   col1_q [3], col1_d [3];
  pix_t   col2_q [3], col2_d [3];
  pix_t   tap [3];
  pix_t   data_out_q, data_out_d;
  logic   valid_out_q, valid_out_d;
  logic   frame_done_q, frame_done_d;
  logic   step, emit, border;
  pix_t   pix, lb0_out, lb1_out;

  logic signed [GRAD_WIDTH-1:0] gx, gy;
  logic        [MAG_WIDTH-1:0]  abs_gx, abs_gy, mag;

  function automatic logic signed [GRAD_WIDTH-1:0] ext(input pix_t p);
    return signed'(GRAD_WIDTH'(p));
  endfunction

  sobel_line_buffer #(.DEPTH(IMAGE_WIDTH), .WIDTH(DATA_COLOR_WIDTH)) u_lb0 (
    .clk(clk), .reset_n(reset_n), .step(step), .din(pix), .dout(lb0_out)
  );

  sobel_line_buffer #(.DEPTH(IMAGE_WIDTH), .WIDTH(DATA_COLOR_WIDTH)) u_lb1 (
    .clk(clk), .reset_n(reset_n), .step(step), .din(lb0_out), .dout(lb1_out)
  );

  // Control: a step is an accepted pixel or a flush tick; outputs start W+1 steps in.
  always_comb begin
    state_d      = state_q;
    in_col_d     = in_col_q;
    in_row_d     = in_row_q;
    out_col_d    = out_col_q;
    out_row_d    = out_row_q;
    flush_cnt_d  = flush_cnt_q;
    lead_cnt_d   = lead_cnt_q;
    step         = 1'b0;
    pix          = io.data_in;
    frame_done_d = 1'b0;

    unique case (state_q)
      IDLE, RUN: begin
        if (io.en && io.valid_in) begin
          step    = 1'b1;
          state_d = RUN;
          if (in_col_q == COL_LAST) begin
            in_col_d = '0;
            in_row_d = in_row_q + 1'b1;
            if (in_row_q == ROW_LAST) state_d = FLUSH;
          end else begin
            in_col_d = in_col_q + 1'b1;
          end
        end
      end
      FLUSH: begin
        pix = '0;
        if (io.en) begin
          step        = 1'b1;
          flush_cnt_d = flush_cnt_q + 1'b1;
          if (flush_cnt_q == FLUSH_LAST) state_d = DONE;
        end
      end
      DONE: begin
        if (io.en) begin
          frame_done_d = 1'b1;
          state_d      = IDLE;
          in_col_d     = '0;
          in_row_d     = '0;
          out_col_d    = '0;
          out_row_d    = '0;
          flush_cnt_d  = '0;
          lead_cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    emit = step && (lead_cnt_q == LEAD_FULL);
    if (step && !emit) lead_cnt_d = lead_cnt_q + 1'b1;
    if (emit) begin
      if (out_col_q == COL_LAST) begin
        out_col_d = '0;
        out_row_d = out_row_q + 1'b1;
      end else begin
        out_col_d = out_col_q + 1'b1;
      end
    end
  end

  // Window rows: index 0 = newest line (p[+1]), 1 = centre line, 2 = oldest line (p[-1]).
  always_comb begin
    tap[0] = pix;
    tap[1] = lb0_out;
    tap[2] = lb1_out;
    for (int i = 0; i < 3; i++) begin
      col1_d[i] = step ? tap[i]    : col1_q[i];
      col2_d[i] = step ? col1_q[i] : col2_q[i];
    end
  end

  // Kernel uses the incoming taps as column +1, so the result lands on this step's edge.
  always_comb begin
    gx = (ext(tap[2]) + (ext(tap[1]) <<< 1) + ext(tap[0]))
       - (ext(col2_q[2]) + (ext(col2_q[1]) <<< 1) + ext(col2_q[0]));
    gy = (ext(col2_q[0]) + (ext(col1_q[0]) <<< 1) + ext(tap[0]))
       - (ext(col2_q[2]) + (ext(col1_q[2]) <<< 1) + ext(tap[2]));
    abs_gx = gx[GRAD_WIDTH-1] ? MAG_WIDTH'(-gx) : MAG_WIDTH'(gx);
    abs_gy = gy[GRAD_WIDTH-1] ? MAG_WIDTH'(-gy) : MAG_WIDTH'(gy);
    mag    = abs_gx + abs_gy;
    border = (out_row_q == '0) || (out_row_q == ROW_LAST) ||
             (out_col_q == '0) || (out_col_q == COL_LAST);

    valid_out_d = emit;
    data_out_d  = data_out_q;
    if (emit) data_out_d = border ? '0 : pix_t'(sat8(mag));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      in_col_q     <= '0;
      in_row_q     <= '0;
      out_col_q    <= '0;
      out_row_q    <= '0;
      flush_cnt_q  <= '0;
      lead_cnt_q   <= '0;
      data_out_q   <= '0;
      valid_out_q  <= 1'b0;
      frame_done_q <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        col1_q[i] <= '0;
        col2_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      in_col_q     <= in_col_d;
      in_row_q     <= in_row_d;
      out_col_q    <= out_col_d;
      out_row_q    <= out_row_d;
      flush_cnt_q  <= flush_cnt_d;
      lead_cnt_q   <= lead_cnt_d;
      data_out_q   <= data_out_d;
      valid_out_q  <= valid_out_d;
      frame_done_q <= frame_done_d;
      for (int i = 0; i < 3; i++) begin
        col1_q[i] <= col1_d[i];
        col2_q[i] <= col2_d[i];
      end
    end
  end

  assign io.data_out   = data_out_q;
  assign io.valid_out  = valid_out_q;
  assign io.frame_done = frame_done_q;
  assign io.busy       = (state_q != IDLE);

endmodule

// File: tb/tb_gray_sobel_edge.sv
// Randomized self-checking bench for gray_sobel_edge against a direct 2-D Sobel reference.
module tb_gray_sobel_edge;

  localparam int H  = 4;
  localparam int W  = 6;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  gray_sobel_edge_if #(.DATA_COLOR_WIDTH(DW)) io ();

  gray_sobel_edge #(
    .IMAGE_HEIGHT(H), .IMAGE_WIDTH(W), .DATA_COLOR_WIDTH(DW),
    .COL_WIDTH(3), .ROW_WIDTH(3)
  ) dut (
    .clk(clk), .reset_n(reset_n), .io(io)
  );

  int         total = 0;
  int         bad = 0;
  int         img [H][W];
  int         exp_q [$];
  logic [7:0] got_q [$];
  int         fd_count = 0;
  logic       en_prev = 1'b1;
  logic       vo_prev = 1'b0;

  // Output monitor: collects pixels, checks en-low silence and frame_done placement.
  always @(posedge clk) en_prev <= io.en;

  always @(negedge clk) begin
    if (io.valid_out === 1'b1) got_q.push_back(io.data_out);
    if (en_prev === 1'b0) begin
      total++;
      if (io.valid_out !== 1'b0 || io.frame_done !== 1'b0) begin
        bad++;
        $display("FAIL en_low_quiet: valid_out=%b frame_done=%b required 0 0", io.valid_out, io.frame_done);
      end
    end
    if (io.frame_done === 1'b1) begin
      fd_count++;
      total++;
      if (vo_prev !== 1'b1) begin
        bad++;
        $display("FAIL frame_done_after_last: prev valid_out=%b required 1", vo_prev);
      end
    end
    vo_prev = io.valid_out;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: Sobel evaluated directly on the 2-D image, borders forced to zero.
  function automatic void build_expected();
    int gx, gy, mag;
    exp_q.delete();
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        if (r == 0 || r == H-1 || c == 0 || c == W-1) begin
          exp_q.push_back(0);
        end else begin
          gx = (img[r-1][c+1] + 2*img[r][c+1] + img[r+1][c+1])
             - (img[r-1][c-1] + 2*img[r][c-1] + img[r+1][c-1]);
          gy = (img[r+1][c-1] + 2*img[r+1][c] + img[r+1][c+1])
             - (img[r-1][c-1] + 2*img[r-1][c] + img[r-1][c+1]);
          mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
          exp_q.push_back(mag > 255 ? 255 : mag);
        end
      end
    end
  endfunction

  function automatic void fill_const(input int v);
    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = v;
  endfunction

  function automatic void fill_ramp();
    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = c * 10;
  endfunction

  function automatic void fill_vstep();
    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = (c < 3) ? 0 : 255;
  endfunction

  function automatic void fill_random();
    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = int'($urandom_range(255));
  endfunction

  task automatic send(input logic v, input logic [7:0] d, input logic e);
    io.valid_in = v;
    io.data_in  = d;
    io.en       = e;
    @(posedge clk);
    #1;
  endtask

  // Feeds img, then keeps valid_in toggling with junk until frame_done (must be ignored).
  task automatic drive_frame(input int gap_pct, input int en_hold_at);
    int k;
    for (int p = 0; p < H*W; p++) begin
      while (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) send(1'b0, 8'($urandom), 1'b1);
      if (p == en_hold_at) repeat (3) send(1'b1, 8'($urandom), 1'b0);
      send(1'b1, 8'(img[p / W][p % W]), 1'b1);
    end
    k = 0;
    while (io.frame_done !== 1'b1 && k < 4*W + 20) begin
      send(1'($urandom), 8'($urandom), 1'b1);
      k++;
    end
    io.valid_in = 1'b0;
    total++;
    if (io.frame_done !== 1'b1) begin
      bad++;
      $display("FAIL frame_done_timeout: frame_done=%b after %0d flush cycles required 1", io.frame_done, k);
    end
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    io.en = 1'b1;
    io.valid_in = 1'b0;
    io.data_in = '0;
    repeat (3) @(posedge clk);
    #1;
    total += 4;
    if (io.valid_out !== 1'b0)  begin bad++; $display("FAIL reset_valid_out: got=%b required=0", io.valid_out); end
    if (io.data_out !== 8'd0)   begin bad++; $display("FAIL reset_data_out: got=%0d required=0", io.data_out); end
    if (io.frame_done !== 1'b0) begin bad++; $display("FAIL reset_frame_done: got=%b required=0", io.frame_done); end
    if (io.busy !== 1'b0)       begin bad++; $display("FAIL reset_busy: got=%b required=0", io.busy); end
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_constant();
    int fd0 = fd_count;
    fill_const(100);
    build_expected();
    got_q.delete();
    drive_frame(0, -1);
    total += 3;
    if (got_q.size() != H*W) begin bad++; $display("FAIL const_count: got=%0d required=%0d", got_q.size(), H*W); end
    if (fd_count != fd0 + 1) begin bad++; $display("FAIL const_frame_done: pulses=%0d required=1", fd_count - fd0); end
    if (io.busy !== 1'b0)    begin bad++; $display("FAIL const_busy_after: got=%b required=0", io.busy); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      total++;
      if (got_q[i] !== 8'(exp_q[i])) begin bad++; $display("FAIL const_pix[%0d]: got=%0d required=%0d", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_ramp();
    fill_ramp();
    build_expected();
    got_q.delete();
    drive_frame(0, -1);
    total++;
    if (got_q.size() != H*W) begin bad++; $display("FAIL ramp_count: got=%0d required=%0d", got_q.size(), H*W); end
    for (int i = 0; i < got_q.size() && i < H*W; i++) begin
      total += 2;
      if (got_q[i] !== 8'(exp_q[i])) begin bad++; $display("FAIL ramp_pix[%0d]: got=%0d required=%0d", i, got_q[i], exp_q[i]); end
      if (got_q[i] !== ((i / W == 0 || i / W == H-1 || i % W == 0 || i % W == W-1) ? 8'd0 : 8'd80)) begin
        bad++;
        $display("FAIL ramp_const[%0d]: got=%0d required interior 80 border 0", i, got_q[i]);
      end
    end
  endtask

  task automatic test_vstep();
    fill_vstep();
    build_expected();
    got_q.delete();
    drive_frame(0, -1);
    total++;
    if (got_q.size() != H*W) begin bad++; $display("FAIL vstep_count: got=%0d required=%0d", got_q.size(), H*W); end
    for (int i = 0; i < got_q.size() && i < H*W; i++) begin
      total++;
      if (got_q[i] !== 8'(exp_q[i])) begin bad++; $display("FAIL vstep_pix[%0d]: got=%0d required=%0d", i, got_q[i], exp_q[i]); end
    end
    for (int r = 1; r < H-1; r++) begin
      if (got_q.size() == H*W) begin
        total += 4;
        if (got_q[r*W+2] !== 8'd255) begin bad++; $display("FAIL vstep_sat_c2[r%0d]: got=%0d required=255", r, got_q[r*W+2]); end
        if (got_q[r*W+3] !== 8'd255) begin bad++; $display("FAIL vstep_sat_c3[r%0d]: got=%0d required=255", r, got_q[r*W+3]); end
        if (got_q[r*W+1] !== 8'd0)   begin bad++; $display("FAIL vstep_flat_c1[r%0d]: got=%0d required=0", r, got_q[r*W+1]); end
        if (got_q[r*W+4] !== 8'd0)   begin bad++; $display("FAIL vstep_flat_c4[r%0d]: got=%0d required=0", r, got_q[r*W+4]); end
      end
    end
  endtask

  task automatic test_gaps();
    fill_ramp();
    build_expected();
    got_q.delete();
    drive_frame(50, 10);
    total++;
    if (got_q.size() != H*W) begin bad++; $display("FAIL gap_ramp_count: got=%0d required=%0d", got_q.size(), H*W); end
    for (int i = 0; i < got_q.size() && i < H*W; i++) begin
      total++;
      if (got_q[i] !== 8'(exp_q[i])) begin bad++; $display("FAIL gap_ramp_pix[%0d]: got=%0d required=%0d", i, got_q[i], exp_q[i]); end
    end
    for (int f = 0; f < 3; f++) begin
      fill_random();
      build_expected();
      got_q.delete();
      drive_frame(50, int'($urandom_range(H*W - 1)));
      total++;
      if (got_q.size() != H*W) begin bad++; $display("FAIL gap_rand_count[f%0d]: got=%0d required=%0d", f, got_q.size(), H*W); end
      for (int i = 0; i < got_q.size() && i < H*W; i++) begin
        total++;
        if (got_q[i] !== 8'(exp_q[i])) begin bad++; $display("FAIL gap_rand_pix[f%0d][%0d]: got=%0d required=%0d", f, i, got_q[i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_reset_mid();
    fill_ramp();
    build_expected();
    for (int p = 0; p <= 7; p++) send(1'b1, 8'(img[p / W][p % W]), 1'b1);
    io.valid_in = 1'b0;
    total += 2;
    if (io.busy !== 1'b1)      begin bad++; $display("FAIL mid_busy: got=%b required=1", io.busy); end
    if (io.valid_out !== 1'b1) begin bad++; $display("FAIL mid_first_out: got=%b required=1", io.valid_out); end
    reset_n = 1'b0;
    #1;
    total += 3;
    if (io.valid_out !== 1'b0) begin bad++; $display("FAIL mid_rst_valid: got=%b required=0", io.valid_out); end
    if (io.data_out !== 8'd0)  begin bad++; $display("FAIL mid_rst_data: got=%0d required=0", io.data_out); end
    if (io.busy !== 1'b0)      begin bad++; $display("FAIL mid_rst_busy: got=%b required=0", io.busy); end
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    got_q.delete();
    drive_frame(0, -1);
    total++;
    if (got_q.size() != H*W) begin bad++; $display("FAIL mid_count: got=%0d required=%0d", got_q.size(), H*W); end
    for (int i = 0; i < got_q.size() && i < H*W; i++) begin
      total++;
      if (got_q[i] !== 8'(exp_q[i])) begin bad++; $display("FAIL mid_pix[%0d]: got=%0d required=%0d", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_back_to_back();
    int fd0 = fd_count;
    for (int f = 0; f < 2; f++) begin
      fill_random();
      build_expected();
      got_q.delete();
      drive_frame(0, -1);
      total++;
      if (got_q.size() != H*W) begin bad++; $display("FAIL b2b_count[f%0d]: got=%0d required=%0d", f, got_q.size(), H*W); end
      for (int i = 0; i < got_q.size() && i < H*W; i++) begin
        total++;
        if (got_q[i] !== 8'(exp_q[i])) begin bad++; $display("FAIL b2b_pix[f%0d][%0d]: got=%0d required=%0d", f, i, got_q[i], exp_q[i]); end
      end
    end
    total++;
    if (fd_count != fd0 + 2) begin bad++; $display("FAIL b2b_frame_done: pulses=%0d required=2", fd_count - fd0); end
  endtask

  initial begin
    test_reset();
    test_constant();
    test_ramp();
    test_vstep();
    test_gaps();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
